// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: EX/MEM and MEM/WB registers, byte/half/word
// data RAM, syscall halt/display, sticky halt flag and run-cycle counter.
module mem_stage #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_signal,
  input  logic [4:0]  in_dst,
  input  logic [31:0] in_r,
  input  logic [31:0] in_r2,
  input  logic [31:0] in_v0,
  input  logic [31:0] in_a0,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir,
  output logic [31:0] out_signal,
  output logic [4:0]  out_dst,
  output logic [31:0] out_r,
  output logic [31:0] out_mem,
  output logic        out_valid,
  output logic        halt,
  output logic [31:0] display,
  output logic [31:0] cycle_cnt
);

  // state      | meaning
  // ST_RUN     | normal operation, counter running
  // ST_HALTED  | halt syscall retired; pipeline frozen until reset
  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t state, state_nxt;

  logic [31:0] ex_pc, ex_ir, ex_sig, ex_r, ex_r2, ex_v0, ex_a0;
  logic [4:0]  ex_dst;
  logic        ex_valid;

  logic              adv;
  logic              sys_halt;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic [MEM_AW-1:0] idx;

  logic [31:0] ram [0:(1<<MEM_AW)-1];

  assign adv      = ex_valid && (state == ST_RUN) && !stall;
  assign sys_halt = adv && ex_sig[13] && (ex_v0 == 32'd10);
  assign idx      = ex_r[MEM_AW+1:2];
  assign rd_word  = ram[idx];
  assign halt     = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ex_pc    <= '0;
      ex_ir    <= '0;
      ex_sig   <= '0;
      ex_dst   <= '0;
      ex_r     <= '0;
      ex_r2    <= '0;
      ex_v0    <= '0;
      ex_a0    <= '0;
      ex_valid <= 1'b0;
    end else if (state == ST_RUN && !stall) begin
      ex_pc    <= in_pc;
      ex_ir    <= in_ir;
      ex_sig   <= in_signal;
      ex_dst   <= in_dst;
      ex_r     <= in_r;
      ex_r2    <= in_r2;
      ex_v0    <= in_v0;
      ex_a0    <= in_a0;
      ex_valid <= 1'b1;
    end
  end

  // Narrow stores replicate the data across lanes and rely on the byte enables.
  always_comb begin
    wr_data = ex_r2;
    wr_be   = 4'b1111;
    if (ex_sig[15]) begin
      wr_data = {4{ex_r2[7:0]}};
      wr_be   = 4'b0001 << ex_r[1:0];
    end else if (ex_sig[16]) begin
      wr_data = {2{ex_r2[15:0]}};
      wr_be   = ex_r[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign wr_en = adv && ex_sig[4] && rst_n;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) ram[idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    ld_half = ex_r[1] ? rd_word[31:16] : rd_word[15:0];
    case (ex_r[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    if (!ex_sig[3])
      ld_data = '0;
    else if (ex_sig[15])
      ld_data = {{24{ex_sig[17] & ld_byte[7]}}, ld_byte};
    else if (ex_sig[16])
      ld_data = {{16{ex_sig[17] & ld_half[15]}}, ld_half};
    else
      ld_data = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !adv) begin
      out_pc     <= '0;
      out_ir     <= '0;
      out_signal <= '0;
      out_dst    <= '0;
      out_r      <= '0;
      out_mem    <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_pc     <= ex_pc;
      out_ir     <= ex_ir;
      out_signal <= ex_sig;
      out_dst    <= ex_dst;
      out_r      <= ex_r;
      out_mem    <= ld_data;
      out_valid  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display   <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state == ST_RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (adv && ex_sig[13] && (ex_v0 == 32'd34)) display <= ex_a0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (sys_halt) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a byte-addressed reference model of the stage.
module tb_mem_stage;

  localparam int MEM_AW    = 10;
  localparam int MEM_BYTES = 4 << MEM_AW;

  localparam logic [31:0] RD  = 32'h1 << 3;
  localparam logic [31:0] WR  = 32'h1 << 4;
  localparam logic [31:0] SYS = 32'h1 << 13;
  localparam logic [31:0] BY  = 32'h1 << 15;
  localparam logic [31:0] HW  = 32'h1 << 16;
  localparam logic [31:0] SX  = 32'h1 << 17;
  localparam logic [31:0] CTRL_MASK = RD | WR | SYS | BY | HW | SX;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_pc = '0, in_ir = '0, in_signal = '0;
  logic [4:0]  in_dst = '0;
  logic [31:0] in_r = '0, in_r2 = '0, in_v0 = '0, in_a0 = '0;
  logic [31:0] out_pc, out_ir, out_signal, out_r, out_mem, display, cycle_cnt;
  logic [4:0]  out_dst;
  logic        out_valid, halt;

  mem_stage #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_pc(in_pc), .in_ir(in_ir), .in_signal(in_signal), .in_dst(in_dst),
    .in_r(in_r), .in_r2(in_r2), .in_v0(in_v0), .in_a0(in_a0),
    .out_pc(out_pc), .out_ir(out_ir), .out_signal(out_signal), .out_dst(out_dst),
    .out_r(out_r), .out_mem(out_mem), .out_valid(out_valid), .halt(halt),
    .display(display), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, ir, sig;
    logic [4:0]  dst;
    logic [31:0] r, r2, v0, a0;
    logic        valid;
  } ent_t;

  // reference model state
  logic [7:0]  mem_b   [MEM_BYTES];
  bit          known_b [MEM_BYTES];
  ent_t        m_ex, m_wb;
  logic [31:0] m_mem, m_disp, m_cnt;
  bit          m_mem_ok, m_halted;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr = 32'h0000_0400;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(input ent_t e, output bit ok);
    int a, b0;
    logic [31:0] w;
    a = int'(e.r % 32'(MEM_BYTES));
    if (e.sig[15]) begin
      ok = known_b[a];
      w  = {24'b0, mem_b[a]};
      if (e.sig[17] && w[7]) w = w | 32'hFFFF_FF00;
    end else if (e.sig[16]) begin
      b0 = a - (a % 2);
      ok = known_b[b0] && known_b[b0+1];
      w  = {16'b0, mem_b[b0+1], mem_b[b0]};
      if (e.sig[17] && w[15]) w = w | 32'hFFFF_0000;
    end else begin
      b0 = a - (a % 4);
      ok = known_b[b0] && known_b[b0+1] && known_b[b0+2] && known_b[b0+3];
      w  = {mem_b[b0+3], mem_b[b0+2], mem_b[b0+1], mem_b[b0]};
    end
    return w;
  endfunction

  task automatic st_model(input ent_t e);
    int a, b0, n;
    a = int'(e.r % 32'(MEM_BYTES));
    if (e.sig[15])      begin b0 = a;             n = 1; end
    else if (e.sig[16]) begin b0 = a - (a % 2);   n = 2; end
    else                begin b0 = a - (a % 4);   n = 4; end
    for (int i = 0; i < n; i++) begin
      mem_b[b0+i]   = e.r2[8*i +: 8];
      known_b[b0+i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit h0, adv;
    if (!rst_n) begin
      m_ex = '0; m_wb = '0; m_mem = '0; m_mem_ok = 1'b1;
      m_halted = 1'b0; m_disp = '0; m_cnt = '0;
    end else begin
      h0  = m_halted;
      adv = m_ex.valid && !h0 && !stall;
      m_wb = '0; m_mem = '0; m_mem_ok = 1'b1;
      if (adv) begin
        m_wb = m_ex;
        if (m_ex.sig[3]) m_mem = ld_val(m_ex, m_mem_ok);
        if (m_ex.sig[4]) st_model(m_ex);
        if (m_ex.sig[13] && m_ex.v0 == 32'd10) m_halted = 1'b1;
        if (m_ex.sig[13] && m_ex.v0 == 32'd34) m_disp = m_ex.a0;
      end
      if (!h0) m_cnt = m_cnt + 32'd1;
      if (flush)
        m_ex = '0;
      else if (!h0 && !stall)
        m_ex = '{pc: in_pc, ir: in_ir, sig: in_signal, dst: in_dst, r: in_r,
                 r2: in_r2, v0: in_v0, a0: in_a0, valid: 1'b1};
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    chk("valid",   {31'b0, out_valid}, {31'b0, m_wb.valid});
    chk("pc",      out_pc,     m_wb.pc);
    chk("ir",      out_ir,     m_wb.ir);
    chk("signal",  out_signal, m_wb.sig);
    chk("dst",     {27'b0, out_dst}, {27'b0, m_wb.dst});
    chk("r",       out_r,      m_wb.r);
    if (m_mem_ok) chk("mem", out_mem, m_mem);
    chk("halt",    {31'b0, halt}, {31'b0, m_halted});
    chk("display", display,    m_disp);
    chk("cnt",     cycle_cnt,  m_cnt);
  endtask

  task automatic drive(input logic [31:0] sig, input logic [31:0] r,
                       input logic [31:0] r2, input logic [31:0] v0, input logic [31:0] a0);
    in_signal = sig;
    in_r      = r;
    in_r2     = r2;
    in_v0     = v0;
    in_a0     = a0;
    in_pc     = pc_ctr;
    in_ir     = $urandom;
    in_dst    = 5'($urandom_range(0, 31));
    pc_ctr    = pc_ctr + 32'd4;
  endtask

  task automatic idle();
    drive($urandom & ~CTRL_MASK, $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    logic [31:0] a, s, v, st_pc;
    int kind, sz, nvalid;

    for (int i = 0; i < MEM_BYTES; i++) known_b[i] = 1'b0;
    m_ex = '0; m_wb = '0; m_mem = '0; m_mem_ok = 1'b1;
    m_halted = 1'b0; m_disp = '0; m_cnt = '0;

    rst_n = 1'b0;
    idle(); cyc();
    idle(); cyc();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;

    // byte/halfword store and load
    drive(WR, 32'h40, 32'h1122_3344, 0, 0);      cyc();
    drive(WR | BY, 32'h41, 32'h0000_00AA, 0, 0); cyc();
    drive(RD, 32'h40, 0, 0, 0);                  cyc();
    drive(RD | BY | SX, 32'h41, 0, 0, 0);        cyc();
    chk("lw_40", out_mem, 32'h1122_AA44);
    drive(RD | BY, 32'h41, 0, 0, 0);             cyc();
    chk("lb_sx", out_mem, 32'hFFFF_FFAA);
    drive(RD | HW | SX, 32'h42, 0, 0, 0);        cyc();
    chk("lbu", out_mem, 32'h0000_00AA);
    idle(); cyc();
    chk("lh_sx", out_mem, 32'h0000_1122);

    // stall holding a store
    st_pc = pc_ctr;
    drive(WR, 32'h80, 32'h5566_7788, 0, 0); cyc();
    stall = 1'b1;
    nvalid = 0;
    repeat (3) begin
      idle(); cyc();
      nvalid += int'(out_valid);
      chk("stall_bubble", {31'b0, out_valid}, 32'd0);
    end
    stall = 1'b0;
    drive(RD, 32'h80, 0, 0, 0); cyc();
    nvalid += int'(out_valid);
    chk("stall_release_pc", out_pc, st_pc);
    chk("stall_one_valid", 32'(nvalid), 32'd1);
    idle(); cyc();
    chk("stall_lw80", out_mem, 32'h5566_7788);

    // flush wins over stall
    drive(WR, 32'h84, 32'h1234_5678, 0, 0); cyc();
    idle(); cyc();
    drive(WR, 32'h84, 32'hFFFF_FFFF, 0, 0);
    flush = 1'b1; stall = 1'b1; cyc();
    flush = 1'b0; stall = 1'b0;
    drive(RD, 32'h84, 0, 0, 0); cyc();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    idle(); cyc();
    chk("flush_nowrite", out_mem, 32'h1234_5678);

    // display syscall
    drive(SYS, 0, 0, 32'd34, 32'hDEAD_BEEF); cyc();
    idle(); cyc();
    chk("disp34", display, 32'hDEAD_BEEF);
    drive(SYS, 0, 0, 32'd5, 32'h0000_0001); cyc();
    idle(); cyc();
    chk("disp5", display, 32'hDEAD_BEEF);

    // address wrap
    drive(WR, 32'h1000, 32'hCAFE_F00D, 0, 0); cyc();
    drive(RD, 32'h0, 0, 0, 0); cyc();
    idle(); cyc();
    chk("wrap", out_mem, 32'hCAFE_F00D);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      sz   = int'($urandom_range(0, 3));
      a    = ($urandom_range(0, 3) << 12) | $urandom_range(0, 255);
      s    = $urandom & ~CTRL_MASK;
      if (sz == 1) s = s | HW;
      if (sz == 2) s = s | BY;
      if (sz == 3) s = s | BY | HW;
      if (kind <= 2) begin
        drive(s | WR, a, $urandom, $urandom, $urandom);
      end else if (kind <= 5) begin
        if ($urandom_range(0, 1) == 1) s = s | SX;
        drive(s | RD, a, $urandom, $urandom, $urandom);
      end else if (kind == 6) begin
        v = ($urandom_range(0, 1) == 1) ? 32'd34 : 32'($urandom_range(11, 100));
        drive((s & ~(BY | HW)) | SYS, a, $urandom, v, $urandom);
      end else begin
        drive(s & ~(BY | HW), $urandom, $urandom, $urandom, $urandom);
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      cyc();
    end
    stall = 1'b0; flush = 1'b0; rst_n = 1'b1;

    drive(WR, 32'h0, 32'hCAFE_F00D, 0, 0); cyc();
    idle(); cyc();

    // reset mid-run drops the in-flight store
    drive(WR, 32'h0, 32'h0BAD_BAD0, 0, 0); cyc();
    rst_n = 1'b0;
    idle(); cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_mem", out_mem, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_display", display, 32'd0);
    chk("rst_cnt2", cycle_cnt, 32'd0);
    rst_n = 1'b1;

    // halt at cycle_cnt 20
    repeat (19) begin idle(); cyc(); end
    drive(SYS, 0, 0, 32'd10, 0); cyc();
    drive(WR, 32'h0, 32'hBAD0_BAD0, 0, 0); cyc();
    chk("halt_set", {31'b0, halt}, 32'd1);
    chk("halt_cnt", cycle_cnt, 32'd21);
    chk("halt_sys_valid", {31'b0, out_valid}, 32'd1);
    repeat (4) begin
      idle(); cyc();
      chk("halted_valid", {31'b0, out_valid}, 32'd0);
      chk("halted_cnt", cycle_cnt, 32'd21);
    end
    rst_n = 1'b0;
    idle(); cyc();
    chk("halt_cleared", {31'b0, halt}, 32'd0);
    rst_n = 1'b1;
    drive(RD, 32'h0, 0, 0, 0); cyc();
    idle(); cyc();
    chk("halt_nowrite", out_mem, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
